// File: rtl/stopwatch_core_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch core: run-control state
// encoding, BCD digit width and the terminal value of each fixed-range digit.
// No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] TENTHS_MAX   = 4'd9;
    localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_ONES_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit of the stopwatch carry chain. Counts 0..MAX and rolls over.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clr       in   synchronous clear to 0
//   en        in   advance request (carry-in from the lower digit)
//   hold      in   freeze the digit even when en is high (saturation)
//   digit     out  registered BCD value
//   carry_out out  en & (digit == MAX), carry-in of the next digit
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             hold,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    logic at_max_s;

    assign at_max_s  = (digit == MAX);
    assign carry_out = en & at_max_s;

    // Digit register: reset/clear first, then hold, else advance with rollover.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit <= 4'd0;
        end else if (en && !hold) begin
            digit <= at_max_s ? 4'd0 : (digit + 4'd1);
        end else begin
            digit <= digit;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// BCD stopwatch MM:SS.t driven by the 100 ms divided clock, which is treated as
// data (two-flop synchronised, rising-edge detected) in the clk domain.
// Optional build macro: STOPWATCH_LAP_EN (lap snapshot/hold of the displayed
// digits). Without it the lap input is ignored.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   tick_in    in   divided clock, one rising edge per 100 ms
//   start_stop in   pulse, toggles run/pause
//   clear      in   pulse, back to 00:00.0 and IDLE (highest priority)
//   lap        in   pulse, lap hold toggle (STOPWATCH_LAP_EN only)
//   tenths, sec_ones, sec_tens, min_ones, min_tens  out  BCD digits
//   running    out  high in RUNNING
//   overflow   out  one-cycle pulse when the count passes the terminal value
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter bit               WRAP         = 1'b1,
    parameter logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    output logic [BCD_W-1:0] tenths,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             overflow
);

    logic             tick_q1_r;
    logic             tick_q2_r;
    logic             adv_s;
    state_t           state_r;
    logic             running_r;
    logic             overflow_r;
    logic             count_en_s;
    logic             terminal_s;
    logic             hold_s;
    logic [4:0]       carry_s;
    logic [BCD_W-1:0] tenths_s;
    logic [BCD_W-1:0] sec_ones_s;
    logic [BCD_W-1:0] sec_tens_s;
    logic [BCD_W-1:0] min_ones_s;
    logic [BCD_W-1:0] min_tens_s;
    logic [5*BCD_W-1:0] live_s;

    // Two-flop synchroniser for the divided clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q1_r <= 1'b0;
            tick_q2_r <= 1'b0;
        end else begin
            tick_q1_r <= tick_in;
            tick_q2_r <= tick_q1_r;
        end
    end

    assign adv_s = tick_q1_r & ~tick_q2_r;

    // A tick is counted only while already RUNNING, so start_stop + adv from
    // IDLE/PAUSED does not count, while in RUNNING it counts before pausing.
    assign count_en_s = adv_s & (state_r == RUNNING) & ~clear;

    assign terminal_s = (min_tens_s == MIN_TENS_MAX) && (min_ones_s == MIN_ONES_MAX) &&
                        (sec_tens_s == SEC_TENS_MAX) && (sec_ones_s == SEC_ONES_MAX) &&
                        (tenths_s == TENTHS_MAX);

    // Saturating build freezes every digit once the terminal value is reached.
    assign hold_s = terminal_s & ~WRAP;

    bcd_digit_counter #(.MAX(TENTHS_MAX)) u_tenths (
        .clk(clk), .rst(rst), .clr(clear), .en(count_en_s), .hold(hold_s),
        .digit(tenths_s), .carry_out(carry_s[0])
    );

    bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .en(carry_s[0]), .hold(hold_s),
        .digit(sec_ones_s), .carry_out(carry_s[1])
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .en(carry_s[1]), .hold(hold_s),
        .digit(sec_tens_s), .carry_out(carry_s[2])
    );

    bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clear), .en(carry_s[2]), .hold(hold_s),
        .digit(min_ones_s), .carry_out(carry_s[3])
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .en(carry_s[3]), .hold(hold_s),
        .digit(min_tens_s), .carry_out(carry_s[4])
    );

    // Run-control FSM with registered running and overflow flags.
    // carry_s[4] is the pass through the terminal value in either mode.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r    <= IDLE;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= carry_s[4];
            case (state_r)
                IDLE: begin
                    if (start_stop) begin
                        state_r   <= RUNNING;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (start_stop || (carry_s[4] && !WRAP)) begin
                        state_r   <= PAUSED;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= RUNNING;
                        running_r <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (start_stop) begin
                        state_r   <= RUNNING;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= PAUSED;
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign live_s   = {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s, tenths_s};
    assign running  = running_r;
    assign overflow = overflow_r;

`ifdef STOPWATCH_LAP_EN
    logic               lap_hold_r;
    logic [5*BCD_W-1:0] snap_r;

    // Lap toggle: capture the live count when entering hold, release on the next lap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_hold_r <= 1'b0;
            snap_r     <= 20'd0;
        end else if (lap && (state_r != IDLE)) begin
            lap_hold_r <= ~lap_hold_r;
            snap_r     <= lap_hold_r ? snap_r : live_s;
        end else begin
            lap_hold_r <= lap_hold_r;
            snap_r     <= snap_r;
        end
    end

    // Output select between two register banks; no input reaches the outputs.
    assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = lap_hold_r ? snap_r : live_s;
`else
    logic unused_lap_s;

    assign unused_lap_s = lap;
    assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = live_s;
`endif

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the 100 ms divided clock produced by the clock-divider stage.
- Runs entirely in the system clock domain. The divided clock is treated as data: it is synchronised and rising-edge detected, never used as a clock.
- Keeps a BCD stopwatch count MM:SS.t (00:00.0 to 59:59.9) under start/stop and clear control.
- Digit outputs feed the seven-segment display scanner.

Parameters:
- WRAP, 1: 1 = wrap 59:59.9 -> 00:00.0 and keep running; 0 = saturate at 59:59.9 and stop.
- MIN_TENS_MAX, 5: terminal value of the minutes-tens digit (5 gives a 59-minute range; legal 1..9).

Ports:
- clk  in  1  system clock (same clock driving the divider stage)
- rst  in  1  synchronous, active-high reset
- tick_in  in  1  divided-clock output from the divider; one rising edge per 100 ms
- start_stop  in  1  single-cycle pulse (debounced upstream); toggles run/pause
- clear  in  1  single-cycle pulse; returns to 00:00.0 and idle
- lap  in  1  single-cycle pulse; used only when STOPWATCH_LAP_EN is defined, ignored otherwise
- tenths  out  4  BCD 0-9
- sec_ones  out  4  BCD 0-9
- sec_tens  out  4  BCD 0-5
- min_ones  out  4  BCD 0-9
- min_tens  out  4  BCD 0..MIN_TENS_MAX
- running  out  1  high in RUNNING state
- overflow  out  1  one-cycle pulse when the count passes 59:59.9

Behaviour:
- Reset, and the rst-high cycle itself:
  - all digits 0; running=0; overflow=0; state IDLE.
  - both sync flops cleared to 0.
- Tick handling:
  - tick_q1 <= tick_in; tick_q2 <= tick_q1; adv = tick_q1 & ~tick_q2.
  - Digits update on the second clk edge after tick_in is first sampled high (fixed 2-cycle latency).
  - A tick_in that is already high at reset release does not count; a rising edge is required.
- States: IDLE (count is zero), RUNNING, PAUSED.
  - IDLE --start_stop--> RUNNING
  - RUNNING --start_stop--> PAUSED
  - PAUSED --start_stop--> RUNNING
  - any state --clear--> IDLE
- Counting:
  - Only in RUNNING with adv=1: tenths increments.
  - Carry ripples within the same cycle: tenths 9->0 carries into sec_ones; 9->0 carries into sec_tens; 5->0 carries into min_ones; 9->0 carries into min_tens.
  - Every digit is always valid BCD; no binary intermediate is ever exposed.
- Terminal count (59:59.9 with adv=1 in RUNNING):
  - WRAP=1: all digits go to 0, overflow pulses for 1 cycle, state remains RUNNING.
  - WRAP=0: digits hold at 59:59.9, overflow pulses for 1 cycle, state goes to PAUSED. Any later start_stop resumes, but the count stays held until clear.
- Simultaneous events:
  - clear has priority over adv, start_stop and lap; the count is zeroed that cycle.
  - start_stop + adv in RUNNING: the tick is counted, then the state becomes PAUSED.
  - start_stop + adv in IDLE or PAUSED: the tick is not counted; the state becomes RUNNING.
- rst or clear mid-count: takes effect at the next clk edge; no partial carry survives.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - A lap pulse in RUNNING or PAUSED toggles a lap_hold flag.
  - While lap_hold=1, the digit outputs show a snapshot taken at the lap pulse, while the internal count keeps advancing.
  - The next lap pulse releases the hold, and outputs show the live count on the following cycle.
  - lap in IDLE is ignored.
  - clear and rst also clear lap_hold.
- Undefined: lap is ignored, no snapshot registers exist, and outputs always show the live count.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUNNING, PAUSED}
  - BCD_W=4
  - digit terminal constants TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9
- Sub-module bcd_digit_counter:
  - parameter MAX.
  - inputs clk, rst, clr, en, hold; outputs digit and carry_out.
  - carry_out = en & (digit==MAX).
  - Instantiated five times in a carry chain; hold implements saturation.

Test Plan:
- Run from IDLE: start_stop, then 25 tick_in rising edges -> 00:02.5, running=1; first increment appears exactly 2 clk edges after the first tick_in rise.
- Pause/resume: pause at 00:01.3, apply 10 ticks -> still 00:01.3; start_stop then 7 ticks -> 00:02.0.
- Clear priority: clear, start_stop and a tick edge in the same cycle while at 12:34.5 -> 00:00.0, state IDLE, running=0.
- Wrap (WRAP=1): preload via ticks to 59:59.9, one tick -> 00:00.0, overflow high for exactly 1 cycle, running=1.
- Saturate (WRAP=0): at 59:59.9, one tick -> holds 59:59.9, overflow 1-cycle pulse, running=0; a further start_stop plus 5 ticks leaves the count at 59:59.9.
- Lap (STOPWATCH_LAP_EN): lap at 00:03.0, 20 ticks -> outputs show 00:03.0; lap again -> outputs show 00:05.0 on the next cycle.
